text_frame_source: RTL

//  Parametrised successor to the fixed 64-char text source: reads CHAR_W-bit characters from an external ROM

---
 rtl/text_frame_source.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/text_frame_source.sv
// Text frame source: reads characters from an external ROM and packs FRAME_CHARS of them per frame.
// Optional per-frame XOR checksum is built only when TEXT_SRC_CHECKSUM_EN is defined.
module text_frame_source #(
    parameter int unsigned CHAR_W      = 8,
    parameter int unsigned FRAME_CHARS = 64,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned START_ADDR  = 0,
    parameter int unsigned END_ADDR    = 255,
    parameter int unsigned ROM_LAT     = 1,
    parameter int unsigned PAD_CHAR    = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    output logic [ADDR_W-1:0]                   rom_addr,
    input  logic [CHAR_W-1:0]                   rom_q,
    output logic [CHAR_W*FRAME_CHARS-1:0]       frame_data,
    output logic                                frame_valid,
    input  logic                                frame_ack,
    output logic [$clog2(FRAME_CHARS+1)-1:0]    frame_count,
    output logic                                frame_last,
    output logic [CHAR_W-1:0]                   frame_csum,
    output logic                                done
);

    localparam int unsigned SLOT_W  = $clog2(FRAME_CHARS);
    localparam int unsigned COUNT_W = $clog2(FRAME_CHARS + 1);
    localparam int unsigned LAT_W   = $clog2(ROM_LAT + 1);
    localparam int unsigned FRAME_W = CHAR_W * FRAME_CHARS;

    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] FINAL_ADDR = ADDR_W'(END_ADDR);
    localparam logic [SLOT_W-1:0] FULL_SLOT  = SLOT_W'(FRAME_CHARS - 1);
    localparam logic [CHAR_W-1:0] PAD        = CHAR_W'(PAD_CHAR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_PAD,
        S_PRESENT,
        S_OFFER,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [SLOT_W-1:0]     slot_q, slot_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  last_q, last_d;
    logic [CHAR_W-1:0]     chars_q [FRAME_CHARS];
    logic [CHAR_W-1:0]     chars_d [FRAME_CHARS];
    logic [ADDR_W-1:0]     rom_addr_d;
    logic [FRAME_W-1:0]    frame_data_d;
    logic                  frame_valid_d;
    logic [COUNT_W-1:0]    frame_count_d;
    logic                  frame_last_d;
    logic                  done_d;
    logic [FRAME_W-1:0]    packed_c;

    // char0 lands in the most significant slot of the frame word
    always_comb begin
        packed_c = '0;
        for (int unsigned i = 0; i < FRAME_CHARS; i++) begin
            packed_c[(FRAME_CHARS - 1 - i) * CHAR_W +: CHAR_W] = chars_q[SLOT_W'(i)];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        slot_d        = slot_q;
        lat_d         = lat_q;
        last_d        = last_q;
        chars_d       = chars_q;
        rom_addr_d    = rom_addr;
        frame_data_d  = frame_data;
        frame_valid_d = frame_valid;
        frame_count_d = frame_count;
        frame_last_d  = frame_last;
        done_d        = done;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    addr_d  = FIRST_ADDR;
                    slot_d  = '0;
                    last_d  = 1'b0;
                    done_d  = 1'b0;
                end
            end
            S_ISSUE: begin
                rom_addr_d = addr_q;
                lat_d      = LAT_W'(ROM_LAT);
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                lat_d = lat_q - LAT_W'(1);
                if (lat_q == LAT_W'(1)) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                chars_d[slot_q] = rom_q;
                if (addr_q == FINAL_ADDR) begin
                    last_d  = 1'b1;
                    state_d = (slot_q == FULL_SLOT) ? S_PRESENT : S_PAD;
                end else if (slot_q == FULL_SLOT) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_PRESENT;
                end else begin
                    slot_d  = slot_q + SLOT_W'(1);
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_ISSUE;
                end
            end
            S_PAD: begin
                for (int unsigned i = 0; i < FRAME_CHARS; i++) begin
                    if (SLOT_W'(i) > slot_q) begin
                        chars_d[SLOT_W'(i)] = PAD;
                    end
                end
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                frame_data_d  = packed_c;
                frame_count_d = COUNT_W'(slot_q) + COUNT_W'(1);
                frame_last_d  = last_q;
                frame_valid_d = 1'b1;
                state_d       = S_OFFER;
            end
            S_OFFER: begin
                if (frame_ack) begin
                    frame_valid_d = 1'b0;
                    if (last_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        slot_d  = '0;
                        state_d = S_ISSUE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= FIRST_ADDR;
            slot_q      <= '0;
            lat_q       <= '0;
            last_q      <= 1'b0;
            for (int unsigned i = 0; i < FRAME_CHARS; i++) begin
                chars_q[SLOT_W'(i)] <= '0;
            end
            rom_addr    <= FIRST_ADDR;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
            frame_last  <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            slot_q      <= slot_d;
            lat_q       <= lat_d;
            last_q      <= last_d;
            chars_q     <= chars_d;
            rom_addr    <= rom_addr_d;
            frame_data  <= frame_data_d;
            frame_valid <= frame_valid_d;
            frame_count <= frame_count_d;
            frame_last  <= frame_last_d;
            done        <= done_d;
        end
    end

`ifdef TEXT_SRC_CHECKSUM_EN
    logic [CHAR_W-1:0] csum_q;

    // Running XOR of real characters only; padding never passes through CAPTURE
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q     <= '0;
            frame_csum <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: if (start) csum_q <= '0;
                S_CAPTURE:      csum_q <= csum_q ^ rom_q;
                S_PRESENT:      frame_csum <= csum_q;
                S_OFFER:        if (frame_ack) csum_q <= '0;
                default:        ;
            endcase
        end
    end
`else
    assign frame_csum = '0;
`endif

endmodule
